// File: rtl/half_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : half_adder_pkg
// Description : Shared defaults, vector types and helper functions for the
//               half_adder_unit lane array and its saturating carry counter.
// Revision    : 1.0 - initial release
// ============================================================================
package half_adder_pkg;

    // Default geometry of a half_adder_unit instance
    localparam int HA_WIDTH_DEF = 1;
    localparam int HA_CNT_W_DEF = 16;

    // Largest lane count and counter width the helpers are sized for.
    // Callers zero-extend into these containers, so any WIDTH <= HA_MAX_WIDTH
    // and CNT_W <= HA_MAX_CNT_W is supported.
    localparam int HA_MAX_WIDTH = 1024;
    localparam int HA_MAX_CNT_W = 63;

    typedef logic [HA_MAX_WIDTH-1:0] lane_vec_t;
    // One spare bit above the widest counter keeps the pre-clamp sum exact
    typedef logic [HA_MAX_CNT_W:0]   cnt_ext_t;

    // Number of set bits in a lane vector (unused upper lanes are zero)
    function automatic cnt_ext_t popcount(input lane_vec_t vec);
        cnt_ext_t n;
        n = '0;
        for (int i = 0; i < HA_MAX_WIDTH; i++) begin
            n = n + cnt_ext_t'(vec[i]);
        end
        return n;
    endfunction

    // Add inc to cur and clamp at 2^cnt_w-1; cur never exceeds the clamp,
    // so the sum cannot overflow the extended container.
    function automatic cnt_ext_t sat_add(input cnt_ext_t cur,
                                         input cnt_ext_t inc,
                                         input int       cnt_w);
        cnt_ext_t lim;
        cnt_ext_t sum;
        lim = (cnt_ext_t'(1) << cnt_w) - cnt_ext_t'(1);
        sum = cur + inc;
        return (sum > lim) ? lim : sum;
    endfunction

endpackage : half_adder_pkg
`default_nettype wire

// File: rtl/half_adder_cell.sv
`default_nettype none
// ============================================================================
// Module      : half_adder_cell
// Description : Single-bit purely combinational half adder (a,b -> s,c).
// Revision    : 1.0 - initial release
// ============================================================================
module half_adder_cell
    import half_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    // Sum and carry of one lane; X/Z on the operands propagates untouched
    assign s = a ^ b;
    assign c = a & b;

endmodule : half_adder_cell
`default_nettype wire

// File: rtl/half_adder_unit.sv
`default_nettype none
// ============================================================================
// Module      : half_adder_unit
// Description : WIDTH independent half-adder lanes with zero-latency outputs,
//               a one-cycle registered copy qualified by out_valid, and a
//               saturating count of accepted lane carries.
// Revision    : 1.0 - initial release
// ============================================================================
module half_adder_unit
    import half_adder_pkg::*;
#(
    parameter int WIDTH = HA_WIDTH_DEF,
    parameter int CNT_W = HA_CNT_W_DEF
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] S_q,
    output logic [WIDTH-1:0] C_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_count
);

    logic [WIDTH-1:0] r_s_q;
    logic [WIDTH-1:0] r_c_q;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_carry_count;

    lane_vec_t        w_carry_vec;
    cnt_ext_t         w_cnt_cur;
    logic [CNT_W-1:0] w_cnt_next;

    // One combinational cell per lane drives the zero-latency outputs
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
            half_adder_cell u_cell (
                .a (A[gi]),
                .b (B[gi]),
                .s (S[gi]),
                .c (C[gi])
            );
        end
    endgenerate

    // Next counter value: current count plus this cycle's carries, clamped
    always_comb begin
        w_carry_vec              = '0;
        w_carry_vec[WIDTH-1:0]   = C;
        w_cnt_cur                = '0;
        w_cnt_cur[CNT_W-1:0]     = r_carry_count;
        w_cnt_next               = CNT_W'(sat_add(w_cnt_cur, popcount(w_carry_vec), CNT_W));
    end

    // Registered lanes, valid flag and counter; reset wins over in_valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s_q         <= '0;
            r_c_q         <= '0;
            r_out_valid   <= 1'b0;
            r_carry_count <= '0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_s_q         <= S;
                r_c_q         <= C;
                r_carry_count <= w_cnt_next;
            end
        end
    end

    assign S_q         = r_s_q;
    assign C_q         = r_c_q;
    assign out_valid   = r_out_valid;
    assign carry_count = r_carry_count;

endmodule : half_adder_unit
`default_nettype wire

// File: tb/tb_half_adder_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_half_adder_unit
// Description : Scoreboard bench for half_adder_unit: a 1-lane/16-bit-counter
//               instance and a 4-lane/3-bit-counter instance share clock,
//               reset and in_valid, and are compared against a lane-arithmetic
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_half_adder_unit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       a1, b1;
    logic [3:0] a4, b4;

    logic        s1, c1, sq1, cq1, ov1;
    logic [15:0] cnt1;
    logic [3:0]  s4, c4, sq4, cq4;
    logic        ov4;
    logic [2:0]  cnt4;

    half_adder_unit #(.WIDTH(1), .CNT_W(16)) u_dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .A           (a1),
        .B           (b1),
        .in_valid    (in_valid),
        .S           (s1),
        .C           (c1),
        .S_q         (sq1),
        .C_q         (cq1),
        .out_valid   (ov1),
        .carry_count (cnt1)
    );

    half_adder_unit #(.WIDTH(4), .CNT_W(3)) u_dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .A           (a4),
        .B           (b4),
        .in_valid    (in_valid),
        .S           (s4),
        .C           (c4),
        .S_q         (sq4),
        .C_q         (cq4),
        .out_valid   (ov4),
        .carry_count (cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        s1;
        logic        c1;
        logic [3:0]  s4;
        logic [3:0]  c4;
        logic [31:0] cnt1;
        logic [31:0] cnt4;
    } exp_t;

    exp_t q_exp[$];
    exp_t hold;
    bit   mon_en = 1'b0;
    int   n_vec  = 0;
    int   n_err  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: each lane is the 2-bit integer sum a+b; bit0 is sum, bit1 carry
    task automatic lane_add(input logic [3:0] a, input logic [3:0] b, input int n,
                            output logic [3:0] s, output logic [3:0] c, output int carries);
        logic [1:0] t;
        s = '0;
        c = '0;
        carries = 0;
        for (int i = 0; i < n; i++) begin
            t = {1'b0, a[i]} + {1'b0, b[i]};
            s[i] = t[0];
            c[i] = t[1];
            carries += int'(t[1]);
        end
    endtask

    // Apply one cycle of stimulus, check combinational outputs, update the model
    task automatic drive(input logic rstn, input logic v, input logic ia1, input logic ib1,
                         input logic [3:0] ia4, input logic [3:0] ib4);
        logic [3:0] es1, ec1, es4, ec4;
        int k1, k4, n1, n4;
        @(negedge clk);
        rst_n = rstn; in_valid = v;
        a1 = ia1; b1 = ib1; a4 = ia4; b4 = ib4;
        lane_add({3'b0, ia1}, {3'b0, ib1}, 1, es1, ec1, k1);
        lane_add(ia4, ib4, 4, es4, ec4, k4);
        #1;
        chk("S1", 32'(s1), 32'(es1[0]));
        chk("C1", 32'(c1), 32'(ec1[0]));
        chk("S4", 32'(s4), 32'(es4));
        chk("C4", 32'(c4), 32'(ec4));
        chk("S4_and_C4", 32'(s4 & c4), 32'd0);
        if (!rstn) begin
            hold = '0;
        end else if (v) begin
            n1 = int'(hold.cnt1) + k1;
            n4 = int'(hold.cnt4) + k4;
            hold.s1   = es1[0];
            hold.c1   = ec1[0];
            hold.s4   = es4;
            hold.c4   = ec4;
            hold.cnt1 = 32'((n1 > 65535) ? 65535 : n1);
            hold.cnt4 = 32'((n4 > 7) ? 7 : n4);
            q_exp.push_back(hold);
        end
        mon_en = 1'b1;
    endtask

    // Monitor: after each edge, a presented output must match a queued entry;
    // otherwise the registered state must be the held model state
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (mon_en) begin
                chk("out_valid1", 32'(ov1), 32'(q_exp.size() != 0));
                chk("out_valid4", 32'(ov4), 32'(q_exp.size() != 0));
                if (q_exp.size() != 0) e = q_exp.pop_front();
                else                   e = hold;
                chk("S_q1", 32'(sq1), 32'(e.s1));
                chk("C_q1", 32'(cq1), 32'(e.c1));
                chk("cnt1", 32'(cnt1), e.cnt1);
                chk("S_q4", 32'(sq4), 32'(e.s4));
                chk("C_q4", 32'(cq4), 32'(e.c4));
                chk("cnt4", 32'(cnt4), e.cnt4);
                chk("S_q4_and_C_q4", 32'(sq4 & cq4), 32'd0);
                chk("S_q1_and_C_q1", 32'(sq1 & cq1), 32'd0);
            end
        end
    end

    // Directed scenarios followed by randomised traffic
    initial begin
        logic [3:0] ts, tc;
        int tk;
        logic [1:0] ab;
        hold = '0;
        rst_n = 1'b0; in_valid = 1'b0;
        a1 = 1'b0; b1 = 1'b0; a4 = 4'h0; b4 = 4'h0;

        // WIDTH=1 truth table, purely combinational, 5 ns apart
        #1;
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            a1 = ab[1]; b1 = ab[0];
            lane_add({3'b0, ab[1]}, {3'b0, ab[0]}, 1, ts, tc, tk);
            #1;
            chk("tt_S", 32'(s1), 32'(ts[0]));
            chk("tt_C", 32'(c1), 32'(tc[0]));
            #4;
        end

        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        // Latency: 1+1 on both; 4-lane 1100+1010 carries one lane
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'b1100, 4'b1010);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 4'h5);
        // Counter saturation on the 3-bit instance: 1+4 = 5, +4 clamps at 7
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 4'hF);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 4'hF);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 4'hF);
        // Reset overrides a valid 1+1 input; combinational carry still high
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF);
        // From zero: two all-ones edges give 8 -> 7, a third keeps 7
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);

        for (int i = 0; i < 1000; i++) begin
            drive(($urandom_range(0, 19) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        @(posedge clk);
        #3;
        chk("queue_drained", 32'(q_exp.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_half_adder_unit
`default_nettype wire
